wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
Write-back stage plus 32-entry general-purpose register file of the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value (load data vs ALU result) and commits it to the register file. Serves the two ID-stage read ports with same-cycle write-through bypass. Exposes the write-back value/destination for the forwarding unit and a committed-write counter for debug.

Parameters:
n, 32, data width of registers and write-back path
CNT_W, 16, width of committed-write counter

Ports:
clk  input  1  pipeline clock, rising-edge
reset_in  input  1  asynchronous, active-low reset (0 = reset asserted)
Reg_Write_in  input  1  write enable from MEM/WB register
MemtoReg_in  input  1  1 = write load data, 0 = write ALU result
data_memory_output_in  input  n  load data from MEM/WB register
ALU_Output_in  input  n  ALU result from MEM/WB register
MEM_WB_Rd_in  input  5  destination register address
rs_addr_in  input  5  ID-stage read address A
rt_addr_in  input  5  ID-stage read address B
rs_data_out  output  n  read data A (combinational)
rt_data_out  output  n  read data B (combinational)
wb_data_out  output  n  selected write-back value (combinational, to forwarding mux)
wb_Rd_out  output  5  MEM_WB_Rd_in gated: equals MEM_WB_Rd_in when Reg_Write_in=1, else 0
wb_count_out  output  CNT_W  number of committed register writes since reset

Behaviour:
- Reset: reset_in low asynchronously clears all 32 registers to 0 and wb_count_out to 0; effective immediately, independent of clk. While reset_in is low no write commits; reads return 0.
- Write-back select: wb_data_out = MemtoReg_in ? data_memory_output_in : ALU_Output_in; purely combinational, also valid when Reg_Write_in=0.
- Commit: on rising clk with reset_in high, Reg_Write_in=1 and MEM_WB_Rd_in != 0 -> reg[MEM_WB_Rd_in] <= wb_data_out, wb_count_out <= wb_count_out + 1. Latency: value architecturally visible from the next edge; visible on read ports in the same cycle via bypass.
- Register 0: hardwired zero. Writes to address 0 are discarded and not counted; reads of address 0 always return 0, including under bypass.
- Read ports: combinational. rs_data_out = (rs_addr_in != 0 && Reg_Write_in && rs_addr_in == MEM_WB_Rd_in) ? wb_data_out : reg[rs_addr_in]; rt identical. Both ports may hit the same address and/or bypass simultaneously.
- Counter: wraps modulo 2^CNT_W (all-ones + 1 -> 0), no saturation, no sticky flag.
- X-safety: when Reg_Write_in=0, no state changes regardless of Rd/data values.
- Reset release mid-pipeline: first edge after reset_in rises commits normally if inputs request it; no extra blanking cycle.
- No stall/flush inputs: bubbles arrive as Reg_Write_in=0 from the MEM/WB register.

Decomposition:
- Shared package: REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0, default data width 32.
- One sub-module: regfile_array (32xn storage, async active-low clear, one write port, two raw combinational read ports). Write-back mux, bypass, r0 masking and counter live in wb_regfile_stage.

Test Plan:
- Reset: drive reset_in=0 mid-cycle after loading reg[5]=0x1234 -> rs_data_out(rs=5)=0 immediately, wb_count_out=0 without a clk edge.
- ALU write: Reg_Write=1, MemtoReg=0, ALU=0xDEADBEEF, Rd=7 -> same cycle rs(7)=0xDEADBEEF via bypass; after edge with Reg_Write=0, rs(7)=0xDEADBEEF; count=1.
- Load write: MemtoReg=1, mem=0x0000_00A5, ALU=0xFFFF_FFFF, Rd=31 -> wb_data_out=0xA5, rt(31)=0xA5 after edge.
- r0: Reg_Write=1, Rd=0, ALU=0x55 -> rs(0)=rt(0)=0 same cycle and after edge; count unchanged; wb_Rd_out=0.
- Dual-port hit: rs=rt=9, Rd=9, ALU=0x77 -> both ports 0x77 same cycle; with Reg_Write=0 both return old reg[9].
- Counter wrap: CNT_W=4, 16 commits to Rd=3 -> wb_count_out returns to 0 after 16th edge; reg[3] holds last value.

Source files
------------

// File: rtl/wb_regfile_stage_pkg.sv
// Shared constants and helpers for the write-back stage and its register file.
package wb_regfile_stage_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int DATA_W_DFLT  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // A read port takes the in-flight write-back value when it names the register being written.
  function automatic logic bypass_hit(input logic [REG_ADDR_W-1:0] rd_addr,
                                      input logic                  wr_en,
                                      input logic [REG_ADDR_W-1:0] wr_addr);
    return (rd_addr != ZERO_REG) && wr_en && (rd_addr == wr_addr);
  endfunction

endpackage

// File: rtl/wb_regfile_stage_regfile_array.sv
// 32 x N register storage: async active-low clear, one write port, two raw read ports.
module regfile_array
  import wb_regfile_stage_pkg::*;
#(
  parameter int N = DATA_W_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [N-1:0]          wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [N-1:0]          rdata_a_o,
  output logic [N-1:0]          rdata_b_o
);

  logic [N-1:0] regs_q [NUM_REGS];

  // Entry 0 is never written, so it stays at its cleared value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != ZERO_REG)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/wb_regfile_stage.sv
// MIPS write-back stage: result select, register-file commit, bypassed reads, write counter.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
#(
  parameter int n     = DATA_W_DFLT,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  Reg_Write_in,
  input  logic                  MemtoReg_in,
  input  logic [n-1:0]          data_memory_output_in,
  input  logic [n-1:0]          ALU_Output_in,
  input  logic [REG_ADDR_W-1:0] MEM_WB_Rd_in,
  input  logic [REG_ADDR_W-1:0] rs_addr_in,
  input  logic [REG_ADDR_W-1:0] rt_addr_in,
  output logic [n-1:0]          rs_data_out,
  output logic [n-1:0]          rt_data_out,
  output logic [n-1:0]          wb_data_out,
  output logic [REG_ADDR_W-1:0] wb_Rd_out,
  output logic [CNT_W-1:0]      wb_count_out
);

  logic           commit;
  logic [n-1:0]   rs_raw;
  logic [n-1:0]   rt_raw;
  logic [CNT_W-1:0] wb_count_q;
  logic [CNT_W-1:0] wb_count_d;

  assign wb_data_out = MemtoReg_in ? data_memory_output_in : ALU_Output_in;
  assign wb_Rd_out   = Reg_Write_in ? MEM_WB_Rd_in : ZERO_REG;
  assign commit      = Reg_Write_in && (MEM_WB_Rd_in != ZERO_REG);

  regfile_array #(.N(n)) u_regfile (
    .clk       (clk),
    .rst_n     (reset_in),
    .we_i      (commit),
    .waddr_i   (MEM_WB_Rd_in),
    .wdata_i   (wb_data_out),
    .raddr_a_i (rs_addr_in),
    .raddr_b_i (rt_addr_in),
    .rdata_a_o (rs_raw),
    .rdata_b_o (rt_raw)
  );

  // Bypass is suppressed in reset so both read ports report the cleared file.
  assign rs_data_out = (reset_in && bypass_hit(rs_addr_in, Reg_Write_in, MEM_WB_Rd_in))
                       ? wb_data_out : rs_raw;
  assign rt_data_out = (reset_in && bypass_hit(rt_addr_in, Reg_Write_in, MEM_WB_Rd_in))
                       ? wb_data_out : rt_raw;

  always_comb begin
    wb_count_d = wb_count_q;
    if (commit) begin
      wb_count_d = wb_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count_out = wb_count_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed plus randomized checks of wb_regfile_stage against an architectural register model.
module tb_wb_regfile_stage;

  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic         clk;
  logic         reset_in;
  logic         Reg_Write_in;
  logic         MemtoReg_in;
  logic [N-1:0] data_memory_output_in;
  logic [N-1:0] ALU_Output_in;
  logic [4:0]   MEM_WB_Rd_in;
  logic [4:0]   rs_addr_in;
  logic [4:0]   rt_addr_in;
  logic [N-1:0] rs_data_out;
  logic [N-1:0] rt_data_out;
  logic [N-1:0] wb_data_out;
  logic [4:0]   wb_Rd_out;
  logic [CNT_W-1:0] wb_count_out;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] model_regs [32];
  int           model_count;

  wb_regfile_stage #(.n(N), .CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .reset_in              (reset_in),
    .Reg_Write_in          (Reg_Write_in),
    .MemtoReg_in           (MemtoReg_in),
    .data_memory_output_in (data_memory_output_in),
    .ALU_Output_in         (ALU_Output_in),
    .MEM_WB_Rd_in          (MEM_WB_Rd_in),
    .rs_addr_in            (rs_addr_in),
    .rt_addr_in            (rt_addr_in),
    .rs_data_out           (rs_data_out),
    .rt_data_out           (rt_data_out),
    .wb_data_out           (wb_data_out),
    .wb_Rd_out             (wb_Rd_out),
    .wb_count_out          (wb_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_wb();
    return MemtoReg_in ? data_memory_output_in : ALU_Output_in;
  endfunction

  // Architectural view of a read: r0 is zero, an in-flight write to the same register wins.
  function automatic logic [N-1:0] exp_read(input logic [4:0] a);
    if (!reset_in || a == 5'd0) return '0;
    if (Reg_Write_in && a == MEM_WB_Rd_in) return exp_wb();
    return model_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_count = 0;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [N-1:0] mem,
                       input logic [N-1:0] alu, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt);
    Reg_Write_in = rw;  MemtoReg_in = m2r;
    data_memory_output_in = mem;  ALU_Output_in = alu;
    MEM_WB_Rd_in = rd;  rs_addr_in = rs;  rt_addr_in = rt;
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rs"},    rs_data_out, exp_read(rs_addr_in));
    check({tag, ".rt"},    rt_data_out, exp_read(rt_addr_in));
    check({tag, ".wb"},    wb_data_out, exp_wb());
    check({tag, ".wbrd"},  N'(wb_Rd_out), Reg_Write_in ? N'(MEM_WB_Rd_in) : '0);
    check({tag, ".count"}, N'(wb_count_out), N'(model_count % (1 << CNT_W)));
  endtask

  // Advance one edge and apply the architectural commit rule to the model.
  task automatic step();
    logic         do_commit;
    logic [4:0]   rd;
    logic [N-1:0] val;
    do_commit = reset_in && Reg_Write_in && (MEM_WB_Rd_in != 5'd0);
    rd  = MEM_WB_Rd_in;
    val = exp_wb();
    @(posedge clk);
    if (do_commit) begin
      model_regs[rd] = val;
      model_count    = (model_count + 1) % (1 << CNT_W);
    end
    #1;
  endtask

  initial begin
    reset_in = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
    model_reset();
    #11;
    check_all("reset_hold");
    reset_in = 1'b1;
    #1;
    check_all("post_release");

    // Load r5 then assert reset mid-cycle: clear must be immediate.
    drive(1'b1, 1'b0, '0, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
    step();
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd5, 5'd0);
    check_all("r5_loaded");
    #2;
    reset_in = 1'b0;
    model_reset();
    #1;
    check("async_reset.rs5", rs_data_out, '0);
    check("async_reset.count", N'(wb_count_out), '0);
    #1;
    reset_in = 1'b1;
    @(posedge clk); #1;

    drive(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd7, 5'd7, 5'd7);
    check("alu_bypass.rs7", rs_data_out, 32'hDEAD_BEEF);
    check_all("alu_write");
    step();
    drive(1'b0, 1'b0, '0, '0, 5'd7, 5'd7, 5'd0);
    check("alu_commit.rs7", rs_data_out, 32'hDEAD_BEEF);
    check("alu_commit.count", N'(wb_count_out), 32'd1);

    drive(1'b1, 1'b1, 32'h0000_00A5, 32'hFFFF_FFFF, 5'd31, 5'd0, 5'd31);
    check("load.wb", wb_data_out, 32'h0000_00A5);
    check_all("load_write");
    step();
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd31);
    check("load_commit.rt31", rt_data_out, 32'h0000_00A5);

    drive(1'b1, 1'b0, '0, 32'h55, 5'd0, 5'd0, 5'd0);
    check("r0_write.rs", rs_data_out, '0);
    check("r0_write.wbrd", N'(wb_Rd_out), '0);
    check_all("r0_write");
    step();
    check("r0_after.count", N'(wb_count_out), 32'd2);
    check_all("r0_after");

    drive(1'b1, 1'b0, '0, 32'h11, 5'd9, 5'd9, 5'd9);
    step();
    drive(1'b1, 1'b0, '0, 32'h77, 5'd9, 5'd9, 5'd9);
    check("dual_hit.rs", rs_data_out, 32'h77);
    check("dual_hit.rt", rt_data_out, 32'h77);
    drive(1'b0, 1'b0, '0, 32'h77, 5'd9, 5'd9, 5'd9);
    check("dual_nowrite.rs", rs_data_out, 32'h11);
    check("dual_nowrite.rt", rt_data_out, 32'h11);
    step();
    check_all("dual_nowrite_after");

    // Random traffic; small destination range keeps bypass hits frequent.
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      check_all("rand");
      step();
    end

    // Counter wrap from a clean reset: 16 commits return to zero.
    reset_in = 1'b0;
    model_reset();
    #1;
    reset_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, '0, N'(32'hA000 + k), 5'd3, 5'd3, 5'd4);
      step();
    end
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd3, 5'd4);
    check("wrap.count", N'(wb_count_out), '0);
    check("wrap.r3", rs_data_out, 32'h0000_A00F);
    check_all("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
